// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port scheduler in front of the CDC FIFO write side.
// One requester is granted at a time for a burst of up to MAX_BURST beats.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic [DATA_WIDTH-1:0]           fifo_write_data,
  output logic                            fifo_write_increment,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic [3:0]                      beat_count
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [GW-1:0] last_q;
  logic [GW-1:0] winner;
  logic [GW-1:0] cand;
  logic          found;
  logic          g_valid;
  logic          g_last;
  logic          beat;
  logic          release_now;

  // Search last+1, last+2, ... with explicit wrap so non-power-of-two NUM_REQ works.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = last_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == GW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    g_valid         = req_valid[grant_id];
    g_last          = req_last[grant_id];
    beat            = busy & g_valid & ~fifo_full;
    req_ready       = '0;
    fifo_write_data = '0;
    if (busy) begin
      req_ready[grant_id] = ~fifo_full;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_id == GW'(i)) fifo_write_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    fifo_write_increment = beat;
    // A requester gap ends the grant even while the FIFO is full.
    release_now = busy & (~g_valid | (beat & (g_last | (beat_count == BURST_LAST))));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      grant_id   <= '0;
      last_q     <= GW'(NUM_REQ - 1);
      beat_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state      <= GRANT;
            busy       <= 1'b1;
            grant_id   <= winner;
            last_q     <= winner;
            beat_count <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state      <= IDLE;
            busy       <= 1'b0;
            beat_count <= '0;
          end else if (beat) begin
            beat_count <= beat_count + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin scheduler that shares the single write port of the CDC FIFO (data, increment, full) between NUM_REQ requesters.
- Sits in the FIFO write-clock domain, directly in front of the FIFO write side.
- Each requester presents beats with a valid/ready handshake. The arbiter grants one requester at a time for a burst of up to MAX_BURST beats.
- It forwards the granted requester's beats into the FIFO, back-pressured by full.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 4, FIFO data width.
- MAX_BURST, 4, maximum beats per grant (1..15).

Ports:
- clk  input  1  write-domain clock (same clock as FIFO write_clock)
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester beat valid
- req_data  input  NUM_REQ*DATA_WIDTH  packed beat data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  input  NUM_REQ  final beat of requester's burst
- req_ready  output  NUM_REQ  per-requester beat accepted
- fifo_full  input  1  FIFO full flag
- fifo_write_data  output  DATA_WIDTH  to FIFO write_data
- fifo_write_increment  output  1  to FIFO write_increment
- grant_id  output  clog2(NUM_REQ)  currently/last granted requester
- busy  output  1  high while in GRANT state
- beat_count  output  4  beats transferred in current grant

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state=IDLE, busy=0, grant_id=0, beat_count=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
  - req_ready=0, fifo_write_increment=0, fifo_write_data=0.
- States: IDLE, GRANT.
- IDLE:
  - req_ready all 0; fifo_write_increment=0.
  - If any req_valid is high: select the first valid requester searching last+1, last+2, ... modulo NUM_REQ.
  - Next cycle: state=GRANT, grant_id=winner, last=winner, beat_count=0, busy=1.
  - Arbitration latency is 1 cycle from valid to grant.
- GRANT, with g=grant_id:
  - req_ready[g] = !fifo_full (combinational); all other req_ready=0.
  - beat = req_valid[g] & req_ready[g].
  - fifo_write_increment = beat (combinational). fifo_write_data = req_data[g] while busy, else 0.
  - On beat: beat_count increments.
- Release GRANT to IDLE at the clock edge when any of these holds:
  - (a) beat with req_last[g]=1;
  - (b) beat with beat_count+1 == MAX_BURST;
  - (c) req_valid[g]=0 (requester gap). No beat occurs in this cycle.
- On release: beat_count clears to 0, busy=0, grant_id holds its value.
- A new grant is always preceded by at least one IDLE cycle, so the minimum inter-burst gap is 1 cycle.
- fifo_full high in GRANT:
  - req_ready[g]=0 and no increment.
  - Grant is held (no release on full alone), beat_count unchanged.
  - Data must not be lost or duplicated.
- A burst cut by MAX_BURST without last: the requester's remaining beats compete again in round-robin order.
- Fairness: a requester continuously valid is granted within NUM_REQ arbitrations.
- Simultaneous events: if last and MAX_BURST coincide on one beat, there is a single release. If req_valid changes on a non-granted requester during GRANT, it has no effect.
- Reset asserted mid-burst: outputs return to reset values immediately (asynchronously). A partially transferred burst is abandoned; beats already written to the FIFO remain.
- Width rule: beat_count is 4 bits, saturating is not needed since MAX_BURST ≤ 15.

Test Plan:
- Reset, then req_valid=0001, data 0xA,0xB,0xC with last on 0xC, fifo_full=0 → grant_id=0 one cycle after valid; increments on 3 consecutive cycles writing A,B,C; busy drops after C; beat_count back to 0.
- req_valid=0011 held, no last, MAX_BURST=4 → grants alternate 0,1,0,1; each grant writes exactly 4 beats; 1 idle cycle between grants.
- Grant to requester 2, fifo_full high for 3 cycles mid-burst after beat 2 → req_ready[2]=0 and increment=0 for those 3 cycles; beats 3..4 follow; total 4 beats written in order, none duplicated.
- Granted requester drops req_valid after 1 beat → release next edge with beat_count=1; another valid requester is granted 1 cycle later in round-robin order.
- All 4 requesters valid with last on each first beat, after reset → grant order 0,1,2,3,0; each writes 1 beat.
- rst_n pulsed low during beat 2 of a burst → busy, req_ready, fifo_write_increment go 0 immediately; after release, requester 0 wins first again (last=NUM_REQ-1).
